// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by a word-organised, byte-writable register array.
// Optional handshake stress (LFSR-gated READY, random B delay) under AXIL_SRAM_BACKPRESSURE_EN.
`timescale 1ns/1ps
module axil_sram_slave #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [31:0]           WDATA,
   input  logic [3:0]            WSTRB,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [31:0]           RDATA,
   output logic [1:0]            RRESP,
   output logic                  RVALID,
   input  logic                  RREADY
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 2;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} rstate_t;

   logic [31:0] mem [DEPTH];

   wstate_t               w_state, w_next;
   rstate_t               r_state, r_next;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic [CNT_W-1:0]      rd_cnt;
   logic                  aw_hs, w_hs, ar_hs;
   logic                  w_err, r_err, commit_c;
   logic                  aw_want, w_want, ar_want;
   logic                  aw_gate, w_gate, ar_gate, dly_done;
   logic [IDX_W-1:0]      w_idx, r_idx;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign w_idx = aw_addr_q[IDX_W+1:2];
   assign r_idx = ARADDR[IDX_W+1:2];
   assign w_err = (aw_addr_q >> (IDX_W + 2)) != '0;
   assign r_err = (ARADDR >> (IDX_W + 2)) != '0;

`ifdef AXIL_SRAM_BACKPRESSURE_EN
   logic [15:0]      lfsr, lfsr_next;
   logic [CNT_W-1:0] dly_cnt;

   // Fibonacci LFSR, taps 16,14,13,11; READY gating looks at the value held in that cycle
   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign aw_gate   = lfsr_next[0];
   assign w_gate    = lfsr_next[1];
   assign ar_gate   = lfsr_next[2];
   assign dly_done  = (dly_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr    <= 16'hACE1;
         dly_cnt <= '0;
      end else begin
         lfsr <= lfsr_next;
         if (w_next == W_COMMIT && w_state != W_COMMIT)
            dly_cnt <= lfsr[4:3];
         else if (w_state == W_COMMIT && !dly_done)
            dly_cnt <= dly_cnt - CNT_W'(1);
      end
   end
`else
   assign aw_gate  = 1'b0;
   assign w_gate   = 1'b0;
   assign ar_gate  = 1'b0;
   assign dly_done = 1'b1;
`endif

   // Write channel next state
   always_comb begin
      w_next   = w_state;
      commit_c = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_next = W_COMMIT;
            else if (aw_hs)    w_next = W_HAVE_AW;
            else if (w_hs)     w_next = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs)  w_next = W_COMMIT;
         W_HAVE_W:  if (aw_hs) w_next = W_COMMIT;
         W_COMMIT: begin
            if (dly_done) begin
               commit_c = 1'b1;
               w_next   = W_RESP;
            end
         end
         W_RESP:    if (BREADY) w_next = W_IDLE;
         default:   w_next = W_IDLE;
      endcase
      aw_want = (w_next == W_IDLE) || (w_next == W_HAVE_W);
      w_want  = (w_next == W_IDLE) || (w_next == W_HAVE_AW);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BRESP   <= OKAY;
      end else begin
         w_state <= w_next;
         AWREADY <= aw_want && !aw_gate;
         WREADY  <= w_want && !w_gate;
         BVALID  <= (w_next == W_RESP);
         if (commit_c) BRESP <= w_err ? SLVERR : OKAY;
         if (aw_hs) aw_addr_q <= AWADDR;
         if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
         end
      end
   end

   // Byte-masked commit; a reset edge suppresses it
   always_ff @(posedge clk) begin
      if (!rst && commit_c && !w_err) begin
         for (int b = 0; b < 4; b++)
            if (w_strb_q[b]) mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
      end
   end

   // Read channel next state
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_WAIT;
         R_WAIT:  if (rd_cnt == '0) r_next = R_VALID;
         R_VALID: if (RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
      ar_want = (r_next == R_IDLE);
   end

   // RDATA is sampled at the AR handshake, so a same-edge write is not visible
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RRESP   <= OKAY;
         RDATA   <= '0;
         rd_cnt  <= '0;
      end else begin
         r_state <= r_next;
         ARREADY <= ar_want && !ar_gate;
         RVALID  <= (r_next == R_VALID);
         if (ar_hs) begin
            RDATA  <= r_err ? ERR_DATA : mem[r_idx];
            RRESP  <= r_err ? SLVERR : OKAY;
            rd_cnt <= CNT_W'(READ_LATENCY - 1);
         end else if (r_state == R_WAIT && rd_cnt != '0) begin
            rd_cnt <= rd_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed self-checking bench for axil_sram_slave (default parameters, feature macro undefined).
`timescale 1ns/1ps
module tb_axil_sram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
   logic [3:0]  WSTRB = '0;
   logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
   logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] RDATA;

   int checks = 0;
   int errors = 0;

   axil_sram_slave dut (
      .clk(clk), .rst(rst),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // W presented w_lead cycles before AW; B held off for bhold cycles
   task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int bhold,
                            input logic [1:0] exp_resp);
      int n, e_aw, e_w, e_b;
      logic hs_aw, hs_w;
      logic [1:0] resp;
      n = 0; e_aw = -1; e_w = -1; e_b = -1;
      AWADDR = addr; WDATA = data; WSTRB = strb;
      WVALID = 1'b1; AWVALID = (w_lead == 0);
      while (e_b < 0 && n < 50) begin
         hs_aw = AWVALID && AWREADY;
         hs_w  = WVALID && WREADY;
         step(); n++;
         if (hs_aw) begin AWVALID = 1'b0; e_aw = n; end
         if (hs_w)  begin WVALID  = 1'b0; e_w  = n; end
         if (e_aw < 0 && !AWVALID && n >= w_lead) AWVALID = 1'b1;
         if (BVALID) e_b = n;
      end
      check({tag, "_bvalid_seen"}, 32'(e_b >= 0), 32'd1);
      if (e_b < 0) begin
         AWVALID = 1'b0; WVALID = 1'b0;
         return;
      end
      check({tag, "_b_latency"}, 32'(e_b - ((e_aw > e_w) ? e_aw : e_w)), 32'd1);
      check({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
      resp = BRESP;
      for (int i = 0; i < bhold; i++) begin
         step();
         check({tag, "_hold_bvalid"}, 32'(BVALID), 32'd1);
         check({tag, "_hold_bresp"}, 32'(BRESP), 32'(resp));
         check({tag, "_hold_readies"}, 32'({AWREADY, WREADY}), 32'd0);
      end
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;
      check({tag, "_b_done"}, 32'({BVALID, AWREADY, WREADY}), 32'b011);
   endtask

   task automatic axi_read(input string tag, input logic [31:0] addr, input int rhold,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int n, e_ar, e_r;
      logic hs;
      logic [31:0] data;
      n = 0; e_ar = -1; e_r = -1;
      ARADDR = addr; ARVALID = 1'b1;
      while (e_r < 0 && n < 50) begin
         hs = ARVALID && ARREADY;
         step(); n++;
         if (hs) begin ARVALID = 1'b0; e_ar = n; end
         if (RVALID) e_r = n;
      end
      check({tag, "_rvalid_seen"}, 32'(e_r >= 0), 32'd1);
      if (e_r < 0) begin
         ARVALID = 1'b0;
         return;
      end
      check({tag, "_r_latency"}, 32'(e_r - e_ar), 32'd1);
      check({tag, "_rdata"}, RDATA, exp_data);
      check({tag, "_rresp"}, 32'(RRESP), 32'(exp_resp));
      data = RDATA;
      for (int i = 0; i < rhold; i++) begin
         step();
         check({tag, "_hold_rvalid"}, 32'(RVALID), 32'd1);
         check({tag, "_hold_rdata"}, RDATA, data);
         check({tag, "_hold_arready"}, 32'(ARREADY), 32'd0);
      end
      RREADY = 1'b1;
      step();
      RREADY = 1'b0;
      check({tag, "_r_done"}, 32'({RVALID, ARREADY}), 32'b01);
   endtask

   initial begin
      // Reset state
      step(); step();
      check("rst_valids", 32'({BVALID, RVALID}), 32'd0);
      check("rst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
      check("rst_resp_data", {RDATA[29:0], BRESP} | 32'(RRESP), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'b111);

      // Preload and basic read
      axi_write("pre0", 32'h00, 32'hA5A5_0000, 4'hF, 0, 0, 2'b00);
      axi_write("pre3", 32'h0C, 32'h1122_3344, 4'hF, 0, 0, 2'b00);
      axi_write("pre4", 32'h10, 32'h0000_0000, 4'hF, 0, 0, 2'b00);
      axi_write("pre7", 32'h1C, 32'h0000_0005, 4'hF, 0, 0, 2'b00);
      axi_write("pre8", 32'h20, 32'h0808_0808, 4'hF, 0, 0, 2'b00);
      axi_read("rd3", 32'h0C, 0, 32'h1122_3344, 2'b00);

      // W two cycles ahead of AW, partial strobe
      axi_write("wlead", 32'h10, 32'hAABB_CCDD, 4'b0101, 2, 0, 2'b00);
      axi_read("rd4", 32'h10, 0, 32'h00BB_00DD, 2'b00);

      // addr[1:0] ignored, WSTRB=0 commits nothing
      axi_read("rd3_unaligned", 32'h0F, 0, 32'h1122_3344, 2'b00);
      axi_write("strb0", 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 2'b00);
      axi_read("rd3_after_strb0", 32'h0C, 0, 32'h1122_3344, 2'b00);

      // Out of range: SLVERR, no aliasing onto word 0
      axi_write("oob_wr", 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10);
      axi_read("rd0_after_oob", 32'h00, 0, 32'hA5A5_0000, 2'b00);
      axi_read("oob_rd", 32'h0000_0400, 0, 32'hDEAD_BEEF, 2'b10);

      // Backpressure on B and R
      axi_write("bhold", 32'h14, 32'h1357_9BDF, 4'hF, 0, 5, 2'b00);
      axi_read("rhold", 32'h14, 5, 32'h1357_9BDF, 2'b00);

      // Same-edge read/write collision on word 7
      AWADDR = 32'h1C; WDATA = 32'h9; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      check("coll_ready_pre", 32'({AWREADY, WREADY, ARREADY}), 32'b111);
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      ARADDR = 32'h1C; ARVALID = 1'b1;
      step();
      ARVALID = 1'b0;
      check("coll_bvalid", 32'(BVALID), 32'd1);
      step();
      check("coll_rvalid", 32'(RVALID), 32'd1);
      check("coll_rdata_old", RDATA, 32'h0000_0005);
      BREADY = 1'b1; RREADY = 1'b1;
      step();
      BREADY = 1'b0; RREADY = 1'b0;
      check("coll_done", 32'({BVALID, RVALID}), 32'd0);
      axi_read("coll_rd_new", 32'h1C, 0, 32'h0000_0009, 2'b00);

      // Reset with write in W_HAVE_AW and read in flight
      AWADDR = 32'h20; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      ARADDR = 32'h0C; ARVALID = 1'b1;
      step();
      ARVALID = 1'b0;
      WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0; WVALID = 1'b0;
      check("midrst_valids", 32'({BVALID, RVALID}), 32'd0);
      check("midrst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
      check("midrst_rdata", RDATA, 32'd0);
      step();
      check("midrst_readies_up", 32'({AWREADY, WREADY, ARREADY}), 32'b111);
      check("midrst_valids_low", 32'({BVALID, RVALID}), 32'd0);
      axi_read("midrst_word8", 32'h20, 0, 32'h0808_0808, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_sram_slave.md
Name: axil_sram_slave

Overview:
- Synthesizable AXI4-Lite slave memory that sits directly downstream of dma_controller.
- Terminates the DMA master's AW/W/B and AR/R channels.
- Backs them with a word-organised, byte-writable register array.
- Serves as both the DMA source and destination memory in system builds and benches, replacing behavioural memory tasks.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DEPTH, 256, number of 32-bit words; power of two, 16..4096.
- READ_LATENCY, 1, cycles from AR handshake to RVALID; legal 1..4.
- ERR_DATA, 32'hDEAD_BEEF, RDATA returned for out-of-range reads.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write byte address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit n covers WDATA[8n+7:8n].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read byte address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Reset (rst=1 at a clock edge): AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RRESP=0, RDATA=0. All pending state is cleared. Memory contents are not cleared. The first cycle after reset deasserts, AWREADY/WREADY/ARREADY=1.
- Reset mid-transaction aborts it; no partial write is committed after the reset edge.
- Word index = addr[$clog2(DEPTH)+1:2]. addr[1:0] is ignored.
- Out of range: any set bit in addr[ADDR_WIDTH-1:$clog2(DEPTH)+2].
- Write path, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - AW and W are accepted independently, in either order or the same cycle. Each is captured into a holding register on its handshake, and its READY drops the next cycle.
  - Once both are held: the memory write is committed on the next edge with per-byte WSTRB masking, and BVALID=1 on that same edge (1 cycle after the last of AW/W).
  - BRESP=SLVERR and no write for out-of-range; OKAY otherwise. WSTRB=0 commits nothing and returns OKAY.
  - BVALID holds, with BRESP stable, until BREADY. On the B handshake, return to W_IDLE with AWREADY=WREADY=1 the next cycle.
  - Exactly one write is outstanding at a time.
- Read path:
  - ARREADY=1 only when no read is in flight.
  - On the AR handshake, ARREADY drops; after READ_LATENCY edges, RVALID=1.
  - RDATA = mem[index] sampled at the AR handshake edge; RRESP=OKAY.
  - Out-of-range: RDATA=ERR_DATA, RRESP=SLVERR.
  - RDATA/RRESP stay stable while RVALID=1 and RREADY=0. On the R handshake, RVALID=0 and ARREADY=1 the next cycle.
  - One read outstanding at a time.
- Read and write are fully independent and may be active simultaneously.
- Same-word collision (read sampled on the same edge the write commits): the read returns the pre-write data.
- Never deasserts VALID before its handshake; never combinationally depends READY on VALID.

Optional Feature:
- Macro AXIL_SRAM_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) advances every cycle.
  - AWREADY, WREADY and ARREADY are additionally gated low in any cycle where lfsr[0]=1, lfsr[1]=1 or lfsr[2]=1 respectively.
  - The added delay before BVALID is lfsr[4:3] cycles.
  - Used to stress dma_controller handshakes.
- Not defined: no LFSR logic; timing exactly as in Behaviour.

Test Plan:
- Preload mem[3]=32'h1122_3344. AR addr 32'h0C with RREADY=1 -> RVALID 1 cycle after handshake (READ_LATENCY=1), RDATA=32'h1122_3344, RRESP=00.
- W (WDATA=32'hAABB_CCDD, WSTRB=4'b0101) two cycles before AW addr 32'h10, where mem[4]=0 -> BVALID 1 cycle after the AW handshake, BRESP=00, mem[4]=32'h00BB_00DD.
- AW addr 32'h0000_0400 (DEPTH=256), WSTRB=4'hF -> BRESP=10, no memory word changes. AR to the same address -> RDATA=32'hDEAD_BEEF, RRESP=10.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY/WREADY/ARREADY remain 0. Handshake completes on release.
- Same-edge read and write to word 7 (old 32'h5, new 32'h9) -> RDATA=32'h5, and a subsequent read returns 32'h9.
- rst asserted while in W_HAVE_AW and with a read in flight -> the next cycle all VALIDs are 0 and the target word is unchanged. dma_controller copy length=5 words from src 32'h0 to dst 32'h40 -> mem[16..20]==mem[0..4], done asserted.
